// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: ID-stage hazard bus between pipeline control (master) and the hazard unit (slave)
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAT_W     = 16
);
  logic                  ID_EX_memRead;
  logic [REG_ADDR_W-1:0] ID_EX_rt;
  logic [REG_ADDR_W-1:0] IF_ID_rs;
  logic [REG_ADDR_W-1:0] IF_ID_rt;
  logic                  IF_ID_useRs;
  logic                  IF_ID_useRt;
  logic                  flush;
  logic                  PCWrite;
  logic                  IF_IDWrite;
  logic                  memRegWriteSelection;
  logic                  stall_active;
  logic [STAT_W-1:0]     stall_cycles;
  modport master (
    output ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_useRs, IF_ID_useRt, flush,
    input  PCWrite, IF_IDWrite, memRegWriteSelection, stall_active, stall_cycles
  );
  modport slave (
    input  ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt, IF_ID_useRs, IF_ID_useRt, flush,
    output PCWrite, IF_IDWrite, memRegWriteSelection, stall_active, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: load-use hazard detector with per-register countdown scoreboard; optional stall counter via HAZARD_STATS_EN
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int STAT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int DEPTH = 2 ** REG_ADDR_W;
  localparam int CW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [CW-1:0] INIT = CW'(LOAD_LATENCY - 1);
  logic [CW-1:0] cnt [DEPTH];
  logic load, match_rs, match_rt, hazard;
  assign load = bus.ID_EX_memRead && bus.ID_EX_rt != '0;
  // An operand matches if it is really read, is not r0, and is either the load in EX or still counting down
  always_comb begin
    match_rs = bus.IF_ID_useRs && bus.IF_ID_rs != '0 &&
               ((bus.ID_EX_memRead && bus.ID_EX_rt == bus.IF_ID_rs) || cnt[bus.IF_ID_rs] != '0);
    match_rt = bus.IF_ID_useRt && bus.IF_ID_rt != '0 &&
               ((bus.ID_EX_memRead && bus.ID_EX_rt == bus.IF_ID_rt) || cnt[bus.IF_ID_rt] != '0);
    hazard   = rst_n && !bus.flush && (match_rs || match_rt);
  end
  assign bus.PCWrite              = !hazard;
  assign bus.IF_IDWrite           = !hazard;
  assign bus.memRegWriteSelection = hazard;
  // Load into EX arms its destination counter; every other busy counter counts down to zero
  always_ff @(posedge clk)
    for (int r = 0; r < DEPTH; r++)
      if (!rst_n) cnt[r] <= '0;
      else if (r != 0 && load && bus.ID_EX_rt == REG_ADDR_W'(r)) cnt[r] <= INIT;
      else if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
  // Registered copy of the stall decision
  always_ff @(posedge clk)
    bus.stall_active <= rst_n && hazard;
`ifdef HAZARD_STATS_EN
  // Saturating count of stalled cycles since reset
  always_ff @(posedge clk)
    if (!rst_n) bus.stall_cycles <= '0;
    else if (hazard && bus.stall_cycles != '1) bus.stall_cycles <= bus.stall_cycles + 1'b1;
`else
  assign bus.stall_cycles = '0;
`endif
endmodule
